overlay_plotter: RTL
====================

OVERLAY_PLOTTER -- requirements
Module: overlay_plotter

Interface
REQ-001 Parameter ROWS, default 27, number of bitmap rows.
REQ-002 Parameter COLS, default 100, number of bitmap columns per row.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to draw the overlay; sampled only in IDLE.
REQ-006 abort  input  1  cancels an in-progress draw.
REQ-007 bitmap  input  ROWS*COLS  packed text bitmap; row r occupies bits [r*COLS+COLS-1 : r*COLS]; row 0 is the top row.
REQ-008 x0  input  8  screen x of bitmap column 0.
REQ-009 y0  input  7  screen y of bitmap row 0.
REQ-010 fg_colour  input  3  colour for set bits.
REQ-011 bg_colour  input  3  colour for clear bits.
REQ-012 x  output  8  pixel x to the VGA adapter.
REQ-013 y  output  7  pixel y to the VGA adapter.
REQ-014 colour  output  3  pixel colour.
REQ-015 plot  output  1  pixel write strobe, one pixel per high cycle.
REQ-016 busy  output  1  high while a draw is in progress.
REQ-017 done  output  1  single-cycle pulse on draw completion.

Function
REQ-018 FSM states IDLE, DRAW, FINISH; IDLE->DRAW on start, DRAW->FINISH after pixel (ROWS-1, COLS-1), FINISH->IDLE unconditionally.
REQ-019 On start accepted at cycle N, bitmap, x0, y0, fg_colour, bg_colour SHALL be latched; later input changes do not affect that draw.
REQ-020 Pixel (col c, row r) SHALL take value bitmap[r*COLS + COLS-1-c], i.e. MSB of each row is leftmost.
REQ-021 Scan order SHALL be row-major: c 0..COLS-1 within r, r 0..ROWS-1; pixel index k = r*COLS + c.
REQ-022 Pixel k SHALL be presented on registered outputs at cycle N+1+k; default full draw = 2700 cycles.
REQ-023 x = (x0 + c) mod 256, y = (y0 + r) mod 128; off-screen wrap is not clipped.
REQ-024 colour = fg_colour for set bits, bg_colour for clear bits.
REQ-025 busy SHALL be high from cycle N+1 through the last pixel cycle, inclusive.
REQ-026 done SHALL be high for exactly cycle N+ROWS*COLS+1 (FINISH), with busy and plot low.
REQ-027 start while busy or in FINISH SHALL be ignored (no queuing).
REQ-028 abort in DRAW SHALL return to IDLE next cycle with plot, busy, done low; abort wins over the last pixel; abort in IDLE is a no-op.
REQ-029 start and abort high together in IDLE SHALL not start a draw.

Reset
REQ-030 resetn low SHALL immediately force IDLE, counters 0, plot=0, busy=0, done=0, x=0, y=0, colour=0.
REQ-031 Reset mid-draw SHALL abandon the draw with no done pulse; the first start after release begins at pixel 0.

Configuration
REQ-032 Macro OVERLAY_TRANSPARENT_EN: when defined, clear bits SHALL keep plot low (x/y still advance, timing unchanged) and bg_colour is unused.
REQ-033 Without OVERLAY_TRANSPARENT_EN, every pixel SHALL be plotted per REQ-024.

Structure
REQ-034 Package overlay_pkg SHALL hold ROWS/COLS defaults, the FSM state typedef, and the 3-bit colour typedef.
REQ-035 Sub-module overlay_scan_counter SHALL provide the col/row counters with a last-pixel flag.

Verification
REQ-036 Default draw, all-zero bitmap except bit 99 set, x0=10,y0=5, fg=3'b100, bg=3'b000 -> first pixel at N+1: x=10,y=5,colour=100; 2700 plot cycles; done at N+2701.
REQ-037 Bit index check: bitmap bit 0 only set -> fg colour only at c=99,r=0 (x=x0+99,y=y0).
REQ-038 x0=200 -> c=56 yields x=0 (wrap); y0=120 -> r=8 yields y=0.
REQ-039 abort at pixel 500 -> plot/busy low next cycle, no done; new start redraws from pixel 0.
REQ-040 start pulsed during DRAW and resetn pulsed mid-draw -> start ignored; reset clears all outputs asynchronously, no done.
REQ-041 With OVERLAY_TRANSPARENT_EN, checkerboard row -> plot high only on set bits; done still at N+2701.

Source files
------------

// File: rtl/overlay_pkg.sv
// overlay_pkg -- shared definitions for the overlay plotter.
//   DEFAULT_ROWS / DEFAULT_COLS : default bitmap geometry (27 x 100)
//   state_t                     : draw sequencer states
//   colour_t                    : 3-bit VGA colour
//   cnt_width()                 : counter width for a count of n values (min 1)
package overlay_pkg;

    localparam int DEFAULT_ROWS = 27;
    localparam int DEFAULT_COLS = 100;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        FINISH
    } state_t;

    typedef logic [2:0] colour_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/overlay_scan_counter.sv
// overlay_scan_counter -- row-major column/row scan position.
//   clock, resetn       : clock, asynchronous active-low reset
//   clear               : return to pixel (0,0); wins over advance
//   advance             : step to the next pixel in row-major order
//   col, row            : pixel currently being presented
//   next_col, next_row  : pixel that follows (col, row)
//   last                : (col, row) is the final pixel (COLS-1, ROWS-1)
module overlay_scan_counter
    import overlay_pkg::*;
#(
    parameter int ROWS = DEFAULT_ROWS,
    parameter int COLS = DEFAULT_COLS,
    parameter int CW   = cnt_width(COLS),
    parameter int RW   = cnt_width(ROWS)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic [CW-1:0] next_col,
    output logic [RW-1:0] next_row,
    output logic          last
);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          col_wrap;

    always_comb begin
        col_wrap = (col_q == CW'(COLS - 1));
        next_col = col_wrap ? '0 : col_q + 1'b1;
        next_row = col_wrap ? row_q + 1'b1 : row_q;
        last     = col_wrap && (row_q == RW'(ROWS - 1));
    end

    // NOTE: state registers use non-blocking (<=) assignments so every flop
    // samples pre-edge values; blocking assignments here would create
    // order-dependent simulation and a sim/synthesis mismatch.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            col_q <= '0;
            row_q <= '0;
        end else if (clear) begin
            col_q <= '0;
            row_q <= '0;
        end else if (advance) begin
            col_q <= next_col;
            row_q <= next_row;
        end
    end

    assign col = col_q;
    assign row = row_q;

endmodule

// File: rtl/overlay_plotter.sv
// overlay_plotter -- streams a packed text bitmap to a VGA adapter, one pixel
// per clock, in row-major order with MSB of each row leftmost.
//   clock, resetn          : clock, asynchronous active-low reset
//   start, abort           : begin a draw (IDLE only) / cancel a draw
//   bitmap                 : ROWS*COLS bits, row r at [r*COLS +: COLS]
//   x0, y0                 : screen origin of bitmap pixel (0,0)
//   fg_colour, bg_colour   : colours for set / clear bits
//   x, y, colour, plot     : registered pixel write to the adapter
//   busy                   : high while pixels are being presented
//   done                   : one-cycle completion pulse
// Build option: OVERLAY_TRANSPARENT_EN -- clear bits are not plotted
// (positions still advance, timing unchanged) and bg_colour is unused.
module overlay_plotter
    import overlay_pkg::*;
#(
    parameter int ROWS = DEFAULT_ROWS,
    parameter int COLS = DEFAULT_COLS
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ROWS*COLS-1:0] bitmap,
    input  logic [7:0]           x0,
    input  logic [6:0]           y0,
    input  logic [2:0]           fg_colour,
    input  logic [2:0]           bg_colour,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [2:0]           colour,
    output logic                 plot,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = cnt_width(COLS);
    localparam int RW = cnt_width(ROWS);
    localparam int IW = cnt_width(ROWS * COLS);

    state_t state_q, state_d;

    // Draw parameters captured when start is accepted.
    logic [ROWS*COLS-1:0] bmp_q;
    logic [7:0]           x0_q;
    logic [6:0]           y0_q;
    colour_t              fg_q;
`ifndef OVERLAY_TRANSPARENT_EN
    colour_t              bg_q;
    colour_t              bg_src;
`endif

    logic          load, clear, advance, last;
    logic [CW-1:0] col, next_col;
    logic [RW-1:0] row, next_row;
    logic [IW-1:0] idx;
    logic          pix_bit;
    colour_t       fg_src;

    logic [7:0] x_d;
    logic [6:0] y_d;
    colour_t    colour_d;
    logic       plot_d, busy_d, done_d;

    overlay_scan_counter #(.ROWS(ROWS), .COLS(COLS), .CW(CW), .RW(RW)) u_scan (
        .clock    (clock),
        .resetn   (resetn),
        .clear    (clear),
        .advance  (advance),
        .col      (col),
        .row      (row),
        .next_col (next_col),
        .next_row (next_row),
        .last     (last)
    );

    // Bitmap bit of the pixel about to be registered; columns run MSB-first.
    assign idx = IW'(int'(next_row) * COLS + (COLS - 1) - int'(next_col));

    // Outputs are registered, so this block computes the pixel that will be
    // visible in the next cycle: pixel 0 straight from the inputs when start
    // is accepted, otherwise the successor of the pixel now on the outputs.
    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        clear    = 1'b0;
        advance  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        x_d      = '0;
        y_d      = '0;
        pix_bit  = 1'b0;
        fg_src   = fg_q;
`ifndef OVERLAY_TRANSPARENT_EN
        bg_src   = bg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = DRAW;
                    load    = 1'b1;
                    clear   = 1'b1;
                    busy_d  = 1'b1;
                    x_d     = x0;
                    y_d     = y0;
                    pix_bit = bitmap[COLS-1];
                    fg_src  = fg_colour;
`ifndef OVERLAY_TRANSPARENT_EN
                    bg_src  = bg_colour;
`endif
                end
            end
            DRAW: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else begin
                    advance = 1'b1;
                    busy_d  = 1'b1;
                    x_d     = x0_q + 8'(next_col);
                    y_d     = y0_q + 7'(next_row);
                    pix_bit = bmp_q[idx];
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        plot_d   = 1'b0;
        colour_d = '0;
        if (busy_d) begin
`ifdef OVERLAY_TRANSPARENT_EN
            plot_d   = pix_bit;
            colour_d = pix_bit ? fg_src : '0;
`else
            plot_d   = 1'b1;
            colour_d = pix_bit ? fg_src : bg_src;
`endif
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            plot    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            x       <= x_d;
            y       <= y_d;
            colour  <= colour_d;
            plot    <= plot_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // NOTE: the captured draw parameters are plain data, always written before
    // they are read, so they carry no reset and cost no reset routing.
    always_ff @(posedge clock) begin
        if (load) begin
            bmp_q <= bitmap;
            x0_q  <= x0;
            y0_q  <= y0;
            fg_q  <= fg_colour;
`ifndef OVERLAY_TRANSPARENT_EN
            bg_q  <= bg_colour;
`endif
        end
    end

endmodule
